// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one fixed-latency memory between IF and DM ports
module mem_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_rd_lat
        $error("mem_port_arbiter: RD_LAT must be in 1..7");
    end

    localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t     state;
    logic [2:0] lat_cnt;
    logic       owner;
    logic       last_gnt;

    logic completing;
    logic eligible;
    logic grant;
    logic win_dm;

    // A read finishing this cycle frees the memory, so a new grant may overlap its return.
    assign completing = (state == RD_WAIT) && (lat_cnt == 3'd1);
    assign eligible   = (state == IDLE) || completing;
    assign grant      = eligible && (if_req || dm_req);

    always_comb begin
        win_dm = 1'b0;
        if (dm_req && !if_req)
            win_dm = 1'b1;
        else if (dm_req && if_req)
            win_dm = ~last_gnt;
    end

    always_comb begin
        if_gnt    = 1'b0;
        dm_gnt    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant) begin
            if_gnt    = ~win_dm;
            dm_gnt    = win_dm;
            mem_en    = 1'b1;
            mem_we    = win_dm & dm_we;
            mem_addr  = win_dm ? dm_addr : if_addr;
            mem_wdata = dm_wdata;
        end
    end

    assign if_rvalid = completing && !owner;
    assign dm_rvalid = completing && owner;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;
    assign busy      = (state == RD_WAIT) && (lat_cnt > 3'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            lat_cnt  <= 3'd0;
            owner    <= 1'b0;
            last_gnt <= 1'b1;
        end else if (grant) begin
            last_gnt <= win_dm;
            if (win_dm && dm_we) begin
                state   <= IDLE;
                lat_cnt <= 3'd0;
            end else begin
                owner   <= win_dm;
                lat_cnt <= LAT_INIT;
                state   <= RD_WAIT;
            end
        end else if (state == RD_WAIT) begin
            lat_cnt <= lat_cnt - 3'd1;
            if (lat_cnt == 3'd1)
                state <= IDLE;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter at RD_LAT 1 and 3
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst1, rst3;
    logic        if_req;
    logic [8:0]  if_addr;
    logic        dm_req, dm_we;
    logic [8:0]  dm_addr;
    logic [31:0] dm_wdata, mem_rdata;

    logic        a_if_gnt, a_if_rvalid, a_dm_gnt, a_dm_rvalid, a_mem_en, a_mem_we, a_busy;
    logic [31:0] a_if_rdata, a_dm_rdata, a_mem_wdata;
    logic [8:0]  a_mem_addr;
    logic        b_if_gnt, b_if_rvalid, b_dm_gnt, b_dm_rvalid, b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_if_rdata, b_dm_rdata, b_mem_wdata;
    logic [8:0]  b_mem_addr;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_W(32), .ADDR_W(9), .RD_LAT(1)) u_lat1 (
        .clk(clk), .reset(rst1),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt),
        .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(a_dm_gnt), .dm_rvalid(a_dm_rvalid), .dm_rdata(a_dm_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata), .busy(a_busy)
    );

    mem_port_arbiter #(.DATA_W(32), .ADDR_W(9), .RD_LAT(3)) u_lat3 (
        .clk(clk), .reset(rst3),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata), .busy(b_busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst1 = 1'b1; rst3 = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        mem_rdata = '0;
        next_cycle();
        next_cycle();
        rst1 = 1'b0; rst3 = 1'b0;
    endtask

    initial begin
        apply_reset();
        @(negedge clk);
        check_eq("rst_mem_en",  {a_mem_en, b_mem_en}, 2'b00);
        check_eq("rst_busy",    {a_busy, b_busy}, 2'b00);
        check_eq("rst_rvalid",  {a_if_rvalid, a_dm_rvalid, b_if_rvalid, b_dm_rvalid}, 4'b0000);

        // Single IF read, RD_LAT = 1
        next_cycle();
        if_req = 1'b1; if_addr = 9'h010;
        @(negedge clk);
        check_eq("t1_if_gnt",   a_if_gnt, 1'b1);
        check_eq("t1_mem_en",   a_mem_en, 1'b1);
        check_eq("t1_mem_addr", a_mem_addr, 9'h010);
        next_cycle();
        if_req = 1'b0; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check_eq("t1_if_rvalid", a_if_rvalid, 1'b1);
        check_eq("t1_if_rdata",  a_if_rdata, 32'hDEADBEEF);
        check_eq("t1_dm_rvalid", a_dm_rvalid, 1'b0);
        check_eq("t1_dm_rdata",  a_dm_rdata, 32'h0);

        // Both requesting reads continuously: IF, DM, IF, DM
        apply_reset();
        if_req = 1'b1; if_addr = 9'h004;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'h100;
        mem_rdata = 32'h0BADF00D;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq($sformatf("t2_gnt_%0d", i), {a_if_gnt, a_dm_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
            check_eq($sformatf("t2_addr_%0d", i), a_mem_addr, (i % 2 == 0) ? 9'h004 : 9'h100);
            if (i > 0)
                check_eq($sformatf("t2_rvalid_%0d", i), {a_if_rvalid, a_dm_rvalid},
                         (i % 2 == 0) ? 2'b01 : 2'b10);
            next_cycle();
        end
        if_req = 1'b0; dm_req = 1'b0;

        // DM write wins over pending IF after an IF grant; IF follows next cycle
        apply_reset();
        if_req = 1'b1; if_addr = 9'h004;
        @(negedge clk);
        check_eq("t3_first_if_gnt", a_if_gnt, 1'b1);
        next_cycle();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 9'h1FF; dm_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        check_eq("t3_gnt",       {a_if_gnt, a_dm_gnt}, 2'b01);
        check_eq("t3_mem_we",    a_mem_we, 1'b1);
        check_eq("t3_mem_addr",  a_mem_addr, 9'h1FF);
        check_eq("t3_mem_wdata", a_mem_wdata, 32'hA5A5A5A5);
        next_cycle();
        dm_req = 1'b0; dm_we = 1'b0;
        @(negedge clk);
        check_eq("t3_if_gnt_next", a_if_gnt, 1'b1);
        check_eq("t3_mem_we_next", a_mem_we, 1'b0);
        check_eq("t3_no_rvalid",   {a_if_rvalid, a_dm_rvalid}, 2'b00);
        next_cycle();
        if_req = 1'b0;

        // RD_LAT = 3: DM blocked while IF read outstanding
        apply_reset();
        if_req = 1'b1; if_addr = 9'h004;
        @(negedge clk);
        check_eq("t4_if_gnt", b_if_gnt, 1'b1);
        check_eq("t4_busy_t", b_busy, 1'b0);
        next_cycle();
        if_req = 1'b0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'h100;
        mem_rdata = 32'h12345678;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            check_eq($sformatf("t4_busy_t%0d", i), b_busy, 1'b1);
            check_eq($sformatf("t4_dm_gnt_t%0d", i), b_dm_gnt, 1'b0);
            check_eq($sformatf("t4_mem_en_t%0d", i), b_mem_en, 1'b0);
            check_eq($sformatf("t4_if_rvalid_t%0d", i), b_if_rvalid, 1'b0);
            next_cycle();
        end
        @(negedge clk);
        check_eq("t4_if_rvalid_t3", b_if_rvalid, 1'b1);
        check_eq("t4_if_rdata_t3",  b_if_rdata, 32'h12345678);
        check_eq("t4_dm_gnt_t3",    b_dm_gnt, 1'b1);
        check_eq("t4_busy_t3",      b_busy, 1'b0);
        check_eq("t4_mem_addr_t3",  b_mem_addr, 9'h100);
        next_cycle();
        dm_req = 1'b0;

        // RD_LAT = 3: reset mid-read drops the outstanding read
        apply_reset();
        if_req = 1'b1; if_addr = 9'h020;
        @(negedge clk);
        check_eq("t5_if_gnt", b_if_gnt, 1'b1);
        next_cycle();
        if_req = 1'b0; rst3 = 1'b1;
        @(negedge clk);
        check_eq("t5_busy_in_rst", b_busy, 1'b0);
        next_cycle();
        rst3 = 1'b0;
        @(negedge clk);
        check_eq("t5_outs_t2", {b_if_rvalid, b_busy, b_mem_en}, 3'b000);
        next_cycle();
        @(negedge clk);
        check_eq("t5_if_rvalid_t3", b_if_rvalid, 1'b0);
        check_eq("t5_if_rdata_t3",  b_if_rdata, 32'h0);

        // Idle for 10 cycles
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq($sformatf("t6_idle_%0d", i),
                     {a_mem_en, a_if_gnt, a_dm_gnt, a_if_rvalid, a_dm_rvalid, a_busy,
                      b_mem_en, b_if_gnt, b_dm_gnt, b_if_rvalid, b_dm_rvalid, b_busy}, 12'h000);
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency memory between the instruction-fetch port (IF, read-only) and the data-memory port (DM, read/write) of the riscv core.
- Grants one transaction at a time using round-robin priority and tracks the outstanding read until its data returns.
- Returns read data to the owning port with an rvalid pulse.
- Sits between the Datapath fetch/memory stages and the shared memory macro. Its busy/grant outputs drive pipeline stalls.

Parameters:
DATA_W, 32, data width of all data buses
ADDR_W, 9, word address width
RD_LAT, 1, memory read latency in cycles (legal 1..7; 0 is illegal and must be caught by an elaboration assertion)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  IF read request; held with if_addr until if_gnt
if_addr  in  ADDR_W  IF read address
if_gnt  out  1  IF request accepted this cycle (combinational)
if_rvalid  out  1  if_rdata valid this cycle
if_rdata  out  DATA_W  IF read data
dm_req  in  1  DM request; held with dm_we/dm_addr/dm_wdata until dm_gnt
dm_we  in  1  1 = write, 0 = read
dm_addr  in  ADDR_W  DM address
dm_wdata  in  DATA_W  DM write data
dm_gnt  out  1  DM request accepted this cycle (combinational)
dm_rvalid  out  1  dm_rdata valid this cycle
dm_rdata  out  DATA_W  DM read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after a read strobe
busy  out  1  a read is outstanding and no grant is possible this cycle

Behaviour:
- State: IDLE / RD_WAIT; lat_cnt (3 bits); owner (0 = IF, 1 = DM); last_gnt (0 = IF, 1 = DM).
- Reset values: state = IDLE, lat_cnt = 0, owner = 0, last_gnt = 1. With last_gnt = 1, IF wins the first conflict.
- Grant-eligible cycle: state == IDLE, or state == RD_WAIT with lat_cnt == 1. In the latter case the read completes this cycle.
- Grant selection in an eligible cycle:
  - Only one requester: that requester wins.
  - Both request: the port not equal to last_gnt wins.
  - No requester: no grant.
- Grant cycle outputs (combinational):
  - Winner's gnt = 1.
  - mem_en = 1, mem_addr = winner address.
  - mem_we = dm_we if DM wins, else 0.
  - mem_wdata = dm_wdata.
  - last_gnt is updated at the clock edge.
- Write grant: complete in the grant cycle. No rvalid. state → IDLE.
- Read grant: owner ← winner, lat_cnt ← RD_LAT, state → RD_WAIT.
- RD_WAIT: lat_cnt decrements each cycle. When lat_cnt == 1:
  - owner's rvalid = 1 and its rdata = mem_rdata (combinational pass-through).
  - state → IDLE, unless a new read is granted the same cycle.
- Throughput: with RD_LAT = 1, back-to-back reads issue every cycle. Otherwise a new grant is earliest RD_LAT cycles after the previous read grant.
- busy = (state == RD_WAIT && lat_cnt > 1).
- Output defaults whenever not granting: gnt = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0. rvalid = 0 and rdata = 0 whenever not returning data.
- Requests seen in a non-eligible cycle get no grant and are re-arbitrated in the next eligible cycle. Requesters must hold req stable until gnt.
- rdata ports are 0 except during their rvalid cycle. The non-owner port never sees rvalid.
- Reset asserted mid-operation: the outstanding read is dropped, no rvalid is produced, and all outputs go to their reset values immediately (async).

Test Plan:
- Reset, RD_LAT = 1: if_req = 1, if_addr = 9'h010 → if_gnt = 1 and mem_en = 1, mem_addr = 9'h010 in the same cycle; next cycle, with mem_rdata = 32'hDEADBEEF, if_rvalid = 1 and if_rdata = 32'hDEADBEEF; dm_rvalid stays 0.
- Both requesting continuously (IF addr 9'h004, DM read addr 9'h100), RD_LAT = 1 → grants alternate IF, DM, IF, DM, starting with IF after reset.
- DM write: dm_we = 1, dm_addr = 9'h1FF, dm_wdata = 32'hA5A5A5A5 → mem_we = 1 with those values in the grant cycle; no rvalid; a pending IF request is granted the next cycle.
- RD_LAT = 3: IF read granted at cycle t; dm_req raised at t+1 → busy = 1 at t+1 and t+2, dm_gnt = 0 at t+1 and t+2; at t+3 if_rvalid = 1 and dm_gnt = 1 in the same cycle.
- RD_LAT = 3: reset pulse at t+1 after a read grant at t → no if_rvalid at t+3; state is IDLE and outputs are 0 after reset release.
- No requests for 10 cycles → mem_en = 0, both gnt = 0, both rvalid = 0, busy = 0 throughout.
